// File: rtl/axi_dma_defs_pkg.sv
// Shared definitions for the DMA read-side AXI blocks: arbiter state encodings and width defaults.
package axi_dma_defs_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int AXI_ADDR_WIDTH_DEF  = 32;
    localparam int AXI_DATA_WIDTH_DEF  = 128;
    localparam int AXI_ID_WIDTH_DEF    = 4;
    localparam int AXI_BURST_WIDTH_DEF = 6;

endpackage

// File: rtl/axi_rd_arb_rr_pick.sv
// Combinational round-robin priority encoder: the first requester after last_grant wins.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] sel,
    output logic             valid
);

    always_comb begin : pick
        int idx;
        // NOTE: blocking assignments and a default for every output keep this purely combinational.
        idx   = 0;
        sel   = '0;
        valid = 1'b0;
        // Scan from the farthest offset down so the closest requester after last_grant overwrites.
        for (int off = N; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % N;
            if (req[idx]) begin
                sel   = IDX_W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read master among NUM_PORTS requesters,
// with an outstanding-burst cap and a broadcast R channel.
module axi_rd_arb
    import axi_dma_defs_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int AXI_ADDR_WIDTH  = AXI_ADDR_WIDTH_DEF,
    parameter int AXI_DATA_WIDTH  = AXI_DATA_WIDTH_DEF,
    parameter int AXI_ID_WIDTH    = AXI_ID_WIDTH_DEF,
    parameter int AXI_BURST_WIDTH = AXI_BURST_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [NUM_PORTS*AXI_ID_WIDTH-1:0]     s_arid,
    input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [NUM_PORTS*AXI_BURST_WIDTH-1:0]  s_arlen,
    input  logic [NUM_PORTS-1:0]                  s_arvalid,
    output logic [NUM_PORTS-1:0]                  s_arready,
    output logic [AXI_ID_WIDTH-1:0]               s_rid,
    output logic [AXI_DATA_WIDTH-1:0]             s_rdata,
    output logic [1:0]                            s_rresp,
    output logic                                  s_rlast,
    output logic                                  s_rvalid,
    output logic [AXI_ID_WIDTH-1:0]               m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]             m_araddr,
    output logic [AXI_BURST_WIDTH-1:0]            m_arlen,
    output logic                                  m_arvalid,
    input  logic                                  m_arready,
    input  logic [AXI_ID_WIDTH-1:0]               m_rid,
    input  logic [AXI_DATA_WIDTH-1:0]             m_rdata,
    input  logic [1:0]                            m_rresp,
    input  logic                                  m_rlast,
    input  logic                                  m_rvalid,
    output logic                                  m_rready,
    output logic                                  busy,
    output logic                                  err_unexp
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   sel, last_grant, pick_sel;
    logic               pick_valid;
    logic [CNT_W-1:0]   out_cnt;
    logic               ar_hs;
    logic               r_done;

    rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
        .req        (s_arvalid),
        .last_grant (last_grant),
        .sel        (pick_sel),
        .valid      (pick_valid)
    );

    assign ar_hs  = (state == ARB_GRANT) && s_arvalid[sel] && m_arready;
    assign r_done = m_rvalid && m_rlast;

    always_comb begin
        state_nxt = state;
        m_arvalid = 1'b0;
        s_arready = '0;
        m_arid    = s_arid[sel*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        m_araddr  = s_araddr[sel*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        m_arlen   = s_arlen[sel*AXI_BURST_WIDTH +: AXI_BURST_WIDTH];
        case (state)
            ARB_IDLE: begin
                if (pick_valid && out_cnt < CNT_W'(MAX_OUTSTANDING))
                    state_nxt = ARB_GRANT;
            end
            ARB_GRANT: begin
                m_arvalid      = s_arvalid[sel];
                s_arready[sel] = m_arready;
                // Requester withdrew before the handshake: abort without touching the fairness pointer.
                if (!s_arvalid[sel] || m_arready)
                    state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= ARB_IDLE;
            sel        <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && state_nxt == ARB_GRANT)
                sel <= pick_sel;
            if (ar_hs)
                last_grant <= sel;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_cnt   <= '0;
            err_unexp <= 1'b0;
        end else begin
            case ({ar_hs, r_done})
                2'b10: out_cnt <= out_cnt + 1'b1;
                2'b01: begin
                    if (out_cnt == '0)
                        err_unexp <= 1'b1;
                    else
                        out_cnt <= out_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (out_cnt != '0);
    assign m_rready = 1'b1;
    assign s_rid    = m_rid;
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;
    assign s_rvalid = m_rvalid;

endmodule
